// File: rtl/imem_responder.sv
// Instruction-fetch responder: a word store with a fixed-latency, fully pipelined read path,
// squash of in-flight fetches on flush, and a program-load write port that takes priority over fetch.
module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] FILL_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] proc2Imem_addr,
  input  logic        proc2Imem_req,
  input  logic        flush,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] Imem2proc_data,
  output logic        Imem2proc_valid,
  output logic        Imem2proc_err,
  output logic        Imem2proc_busy,
  output logic [2:0]  inflight_cnt
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Handshake: a fetch is taken on any rising edge where proc2Imem_req=1 and load_en=0;
  // there is no backpressure, and a taken fetch answers with exactly one valid cycle
  // LATENCY edges later unless a flush or reset intervenes. busy flags a dropped request.
  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] fetch_idx;
  logic [AW-1:0] load_idx;
  logic          fetch_oor;
  logic          load_oor;
  logic          accept;
  logic [2:0]    cnt_next;

  logic [LATENCY-1:0] stg_valid;
  logic [LATENCY-1:0] stg_err;
  logic [31:0]        stg_data [LATENCY];

  assign fetch_idx = proc2Imem_addr[AW+1:2];
  assign load_idx  = load_addr[AW+1:2];
  assign fetch_oor = |proc2Imem_addr[31:AW+2];
  assign load_oor  = |load_addr[31:AW+2];
  assign accept    = proc2Imem_req & ~load_en;

  assign Imem2proc_busy = proc2Imem_req & load_en;

  // Storage has no reset so program contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (load_en && !load_oor) begin
      mem[load_idx] <= load_data;
    end
  end

  // A fetch accepted on a flush edge is the branch target, so only older stages are squashed.
  always_comb begin
    cnt_next = inflight_cnt;
    if (flush) begin
      cnt_next = {2'b00, accept};
    end else begin
      cnt_next = inflight_cnt + {2'b00, accept} - {2'b00, stg_valid[LATENCY-1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_valid    <= '0;
      stg_err      <= '0;
      inflight_cnt <= 3'd0;
      for (int k = 0; k < LATENCY; k++) begin
        stg_data[k] <= FILL_WORD;
      end
    end else begin
      stg_valid[0] <= accept;
      stg_err[0]   <= accept & fetch_oor;
      stg_data[0]  <= (accept && !fetch_oor) ? mem[fetch_idx] : FILL_WORD;
      for (int k = 1; k < LATENCY; k++) begin
        stg_valid[k] <= stg_valid[k-1] & ~flush;
        stg_err[k]   <= stg_err[k-1];
        stg_data[k]  <= stg_data[k-1];
      end
      inflight_cnt <= cnt_next;
    end
  end

  assign Imem2proc_valid = stg_valid[LATENCY-1];
  assign Imem2proc_err   = stg_valid[LATENCY-1] & stg_err[LATENCY-1];
  assign Imem2proc_data  = stg_valid[LATENCY-1] ? stg_data[LATENCY-1] : FILL_WORD;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 1, 2, 4) share stimulus and are checked
// every cycle against an event-history model of accepts, flushes and resets.
module tb_imem_responder;

  localparam int DEPTH = 1024;
  localparam int NE    = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        req;
  logic        flush;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic [31:0] d_o [3];
  logic        v_o [3];
  logic        e_o [3];
  logic        b_o [3];
  logic [2:0]  c_o [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
      .FILL_WORD  (32'h0000_0000)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .proc2Imem_addr (addr),
      .proc2Imem_req  (req),
      .flush          (flush),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .Imem2proc_data (d_o[g]),
      .Imem2proc_valid(v_o[g]),
      .Imem2proc_err  (e_o[g]),
      .Imem2proc_busy (b_o[g]),
      .inflight_cnt   (c_o[g])
    );
  end

  // Reference model: storage image plus a per-edge history of what happened.
  logic [31:0] mem_m  [DEPTH];
  bit          acc_v  [NE];
  logic [31:0] acc_d  [NE];
  bit          acc_e  [NE];
  bit          fl_at  [NE];
  int          last_rst = 0;
  int          edge_n   = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          peak2    = 0;

  function automatic int lat_of(int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_n, obs, exp);
    end
  endtask

  // A fetch accepted at edge a is visible after edge a+L-1, provided no flush hit it at a
  // later edge and no reset occurred at or after it.
  task automatic model_out(input int lat, input int e, output logic v, output logic [31:0] d,
                           output logic er, output logic [2:0] cnt);
    bit alive;
    v = 1'b0; d = 32'h0; er = 1'b0; cnt = 3'd0;
    for (int a = e - lat + 1; a <= e; a++) begin
      if (a < 1 || a <= last_rst || !acc_v[a]) continue;
      alive = 1'b1;
      for (int f = a + 1; f <= e; f++) if (fl_at[f]) alive = 1'b0;
      if (!alive) continue;
      cnt = cnt + 3'd1;
      if (a == e - lat + 1) begin
        v = 1'b1; d = acc_d[a]; er = acc_e[a];
      end
    end
  endtask

  task automatic model_edge(input int e);
    int idx;
    bit oor;
    acc_v[e] = 1'b0; acc_e[e] = 1'b0; acc_d[e] = 32'h0; fl_at[e] = 1'b0;
    if (!rst) begin
      last_rst = e;
    end else begin
      idx = int'(addr >> 2);
      oor = (addr >> 2) >= DEPTH;
      if (req && !load_en) begin
        acc_v[e] = 1'b1;
        acc_e[e] = oor;
        acc_d[e] = oor ? 32'h0 : mem_m[idx % DEPTH];
      end
      fl_at[e] = flush;
      if (load_en && (load_addr >> 2) < DEPTH) mem_m[int'(load_addr >> 2)] = load_data;
    end
  endtask

  task automatic check_all(input string phase);
    logic        v, er;
    logic [31:0] d;
    logic [2:0]  cnt;
    for (int g = 0; g < 3; g++) begin
      model_out(lat_of(g), edge_n, v, d, er, cnt);
      check($sformatf("%s L%0d valid", phase, lat_of(g)), {31'b0, v_o[g]}, {31'b0, v});
      check($sformatf("%s L%0d data", phase, lat_of(g)), d_o[g], d);
      check($sformatf("%s L%0d err", phase, lat_of(g)), {31'b0, e_o[g]}, {31'b0, er});
      check($sformatf("%s L%0d cnt", phase, lat_of(g)), {29'b0, c_o[g]}, {29'b0, cnt});
    end
  endtask

  // One clock: check busy on current inputs, let the edge happen, then check outputs.
  task automatic step();
    #1;
    for (int g = 0; g < 3; g++)
      check($sformatf("L%0d busy", lat_of(g)), {31'b0, b_o[g]}, {31'b0, req & load_en});
    @(posedge clk);
    edge_n++;
    model_edge(edge_n);
    @(negedge clk);
    check_all("cyc");
    if (int'(c_o[1]) > peak2) peak2 = int'(c_o[1]);
  endtask

  task automatic drive_idle();
    req = 1'b0; flush = 1'b0; load_en = 1'b0; addr = 32'h0; load_addr = 32'h0; load_data = 32'h0;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic fl);
    drive_idle();
    req = 1'b1; addr = a; flush = fl;
    step();
  endtask

  task automatic drive_load(input logic [31:0] a, input logic [31:0] dat, input logic with_req);
    drive_idle();
    load_en = 1'b1; load_addr = a; load_data = dat;
    req = with_req; addr = a;
    step();
  endtask

  task automatic idle(input int n);
    drive_idle();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_reset();
    drive_idle();
    rst = 1'b0;
    last_rst = edge_n;
    #1;
    check_all("rst");
    step();
    rst = 1'b1;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check("reset valid", {31'b0, v_o[g]}, 32'h0);
      check("reset data", d_o[g], 32'h0);
      check("reset err", {31'b0, e_o[g]}, 32'h0);
      check("reset cnt", {29'b0, c_o[g]}, 32'h0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) drive_load(32'(i * 4), $urandom, 1'b0);

    // Back-to-back fetches after loading a known program.
    drive_load(32'h0, 32'h11, 1'b0);
    drive_load(32'h4, 32'h22, 1'b0);
    drive_load(32'h8, 32'h33, 1'b0);
    drive_load(32'hC, 32'h44, 1'b0);
    peak2 = 0;
    drive_req(32'h0, 1'b0);
    drive_req(32'h4, 1'b0);
    drive_req(32'h8, 1'b0);
    drive_req(32'hC, 1'b0);
    idle(5);
    check("L2 inflight peak", 32'(peak2), 32'd2);

    drive_req(32'h0000_1000, 1'b0);
    idle(5);

    drive_req(32'h0, 1'b0);
    drive_req(32'hC, 1'b1);
    check("L2 cnt after flush", {29'b0, c_o[1]}, 32'd1);
    idle(5);

    drive_load(32'h8, 32'hDEAD_BEEF, 1'b1);
    drive_req(32'h8, 1'b0);
    idle(5);

    drive_req(32'h0, 1'b0);
    drive_req(32'h4, 1'b0);
    drive_req(32'h8, 1'b0);
    pulse_reset();
    drive_req(32'h0, 1'b0);
    idle(5);

    drive_req(32'h5, 1'b0);
    idle(5);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        drive_idle();
        req     = ($urandom_range(0, 9) < 7);
        flush   = ($urandom_range(0, 9) == 0);
        load_en = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 9) == 0) addr = $urandom | 32'h0000_1000;
        else addr = {20'h0, 10'($urandom_range(0, 15)), 2'($urandom)};
        load_addr = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_1000)
                                                : {20'h0, 10'($urandom_range(0, 15)), 2'b00};
        load_data = $urandom;
        step();
      end
    end
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
